// File: rtl/wash_controller_if.sv
// rtl/wash_controller_if.sv - command, sensor, state and actuator signals of the wash controller
interface wash_controller_if;
  logic       start;
  logic       cancel;
  logic       door_Closed;
  logic       sig_Full;
  logic       sig_Temperature;
  logic       sig_Completed;
  logic [2:0] state;
  logic       door_Lock;
  logic       water_Valve;
  logic       heater_On;
  logic       motor_On;
  logic       drain_On;
  logic       done;
  logic       fault;

  modport master (
    input  start, cancel, door_Closed, sig_Full, sig_Temperature, sig_Completed,
    output state, door_Lock, water_Valve, heater_On, motor_On, drain_On, done, fault
  );

  modport slave (
    output start, cancel, door_Closed, sig_Full, sig_Temperature, sig_Completed,
    input  state, door_Lock, water_Valve, heater_On, motor_On, drain_On, done, fault
  );
endinterface

// File: rtl/wash_controller.sv
// rtl/wash_controller.sv - washing machine sequencer with dwell watchdog; WASH_EXTRA_RINSE_EN adds a second rinse pass
module wash_controller #(
  parameter int WDOG_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset,
  wash_controller_if.master bus
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LOCK        = 3'd1,
    FILL_WATER  = 3'd2,
    HEAT_WATER  = 3'd3,
    WASH        = 3'd4,
    RINSE       = 3'd5,
    SPIN        = 3'd6,
    DONE        = 3'd7
  } state_t;

  localparam logic [7:0] WDOG_LAST = 8'(WDOG_CYCLES - 1);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] dwell_q;
  logic [7:0] dwell_d;
  logic       fault_q;
  logic       fault_d;
  logic       active;
  logic       timeout;
  logic       door_lock_q;
  logic       water_valve_q;
  logic       heater_on_q;
  logic       motor_on_q;
  logic       drain_on_q;
  logic       done_q;
`ifdef WASH_EXTRA_RINSE_EN
  logic       rinse_q;
  logic       rinse_d;
`endif

  assign active  = (state_q >= FILL_WATER) && (state_q <= SPIN);
  assign timeout = active && (dwell_q == WDOG_LAST);

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
`ifdef WASH_EXTRA_RINSE_EN
    rinse_d = rinse_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start && bus.door_Closed) begin
          state_d = LOCK;
          fault_d = 1'b0;
        end
      end
      LOCK: begin
        if (bus.cancel || !bus.door_Closed) state_d = IDLE;
        else                                state_d = FILL_WATER;
      end
      FILL_WATER: begin
`ifdef WASH_EXTRA_RINSE_EN
        if (bus.sig_Full) state_d = rinse_q ? RINSE : HEAT_WATER;
`else
        if (bus.sig_Full) state_d = HEAT_WATER;
`endif
      end
      HEAT_WATER: if (bus.sig_Temperature) state_d = WASH;
      WASH:       if (bus.sig_Completed)   state_d = RINSE;
      RINSE: begin
`ifdef WASH_EXTRA_RINSE_EN
        if (bus.sig_Completed) begin
          state_d = rinse_q ? SPIN : FILL_WATER;
          rinse_d = !rinse_q;
        end
`else
        if (bus.sig_Completed) state_d = SPIN;
`endif
      end
      SPIN:       if (bus.sig_Completed)   state_d = DONE;
      DONE:       if (!bus.start)          state_d = IDLE;
      default:    state_d = IDLE;
    endcase

    // Priority: watchdog over cancel over the state's own event.
    if (active && state_q != SPIN && bus.cancel) state_d = SPIN;
    if (timeout) begin
      state_d = (state_q == SPIN) ? IDLE : SPIN;
      fault_d = 1'b1;
    end
`ifdef WASH_EXTRA_RINSE_EN
    if (state_d == SPIN || state_d == IDLE) rinse_d = 1'b0;
`endif

    if (state_d != state_q || !active) dwell_d = 8'd0;
    else if (dwell_q != 8'hFF)         dwell_d = dwell_q + 8'd1;
    else                               dwell_d = dwell_q;
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      dwell_q       <= 8'd0;
      fault_q       <= 1'b0;
      door_lock_q   <= 1'b0;
      water_valve_q <= 1'b0;
      heater_on_q   <= 1'b0;
      motor_on_q    <= 1'b0;
      drain_on_q    <= 1'b0;
      done_q        <= 1'b0;
`ifdef WASH_EXTRA_RINSE_EN
      rinse_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      dwell_q       <= dwell_d;
      fault_q       <= fault_d;
      door_lock_q   <= (state_d != IDLE) && (state_d != DONE);
      water_valve_q <= (state_d == FILL_WATER);
      heater_on_q   <= (state_d == HEAT_WATER);
      motor_on_q    <= (state_d == WASH) || (state_d == RINSE) || (state_d == SPIN);
      drain_on_q    <= (state_d == SPIN);
      done_q        <= (state_d == DONE);
`ifdef WASH_EXTRA_RINSE_EN
      rinse_q       <= rinse_d;
`endif
    end
  end

  assign bus.state       = state_q;
  assign bus.door_Lock   = door_lock_q;
  assign bus.water_Valve = water_valve_q;
  assign bus.heater_On   = heater_on_q;
  assign bus.motor_On    = motor_on_q;
  assign bus.drain_On    = drain_on_q;
  assign bus.done        = done_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_wash_controller.sv
// tb/tb_wash_controller.sv - directed-vector bench for wash_controller (WDOG_CYCLES=8)
module tb_wash_controller;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  wash_controller_if bus ();

  wash_controller #(.WDOG_CYCLES(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  // {door_Lock, water_Valve, heater_On, motor_On, drain_On, done, fault}
  localparam logic [6:0] F_IDLE = 7'b0000000;
  localparam logic [6:0] F_LOCK = 7'b1000000;
  localparam logic [6:0] F_FILL = 7'b1100000;
  localparam logic [6:0] F_HEAT = 7'b1010000;
  localparam logic [6:0] F_WASH = 7'b1001000;
  localparam logic [6:0] F_SPIN = 7'b1001100;
  localparam logic [6:0] F_DONE = 7'b0000010;
  localparam logic [6:0] F_FLT  = 7'b0000001;

  function automatic logic [6:0] flags();
    return {bus.door_Lock, bus.water_Valve, bus.heater_On, bus.motor_On,
            bus.drain_On, bus.done, bus.fault};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_st(input string tag, input int st, input logic [6:0] fl);
    check({tag, ".state"}, 32'(bus.state), 32'(st));
    check({tag, ".flags"}, 32'(flags()), 32'(fl));
  endtask

  task automatic pulse(input int which);
    bus.sig_Full        = (which == 1);
    bus.sig_Temperature = (which == 2);
    bus.sig_Completed   = (which == 3);
    step();
    bus.sig_Full = 1'b0; bus.sig_Temperature = 1'b0; bus.sig_Completed = 1'b0;
  endtask

  task automatic run_to_wash(input string tag);
    bus.start = 1'b1; bus.door_Closed = 1'b1;
    step(); expect_st({tag, ".lock"}, 1, F_LOCK);
    step(); expect_st({tag, ".fill"}, 2, F_FILL);
    pulse(1); expect_st({tag, ".heat"}, 3, F_HEAT);
    pulse(2); expect_st({tag, ".wash"}, 4, F_WASH);
  endtask

  initial begin
    bus.start = 1'b0; bus.cancel = 1'b0; bus.door_Closed = 1'b0;
    bus.sig_Full = 1'b0; bus.sig_Temperature = 1'b0; bus.sig_Completed = 1'b0;
    #12;
    expect_st("reset", 0, F_IDLE);
    reset = 1'b0;
    step(); expect_st("idle_after_reset", 0, F_IDLE);

    // Nominal run, with out-of-place sig_* events ignored
    bus.start = 1'b1; bus.door_Closed = 1'b1;
    step(); expect_st("nom.lock", 1, F_LOCK);
    step(); expect_st("nom.fill", 2, F_FILL);
    pulse(3); expect_st("nom.fill_ignore", 2, F_FILL);
    pulse(1); expect_st("nom.heat", 3, F_HEAT);
    pulse(1); expect_st("nom.heat_ignore", 3, F_HEAT);
    pulse(2); expect_st("nom.wash", 4, F_WASH);
    pulse(2); expect_st("nom.wash_ignore", 4, F_WASH);
    pulse(3); expect_st("nom.rinse", 5, F_WASH);
`ifdef WASH_EXTRA_RINSE_EN
    pulse(3); expect_st("nom.refill", 2, F_FILL);
    pulse(1); expect_st("nom.rinse2", 5, F_WASH);
`endif
    pulse(3); expect_st("nom.spin", 6, F_SPIN);
    pulse(3); expect_st("nom.done", 7, F_DONE);
    step();   expect_st("nom.done_hold", 7, F_DONE);
    bus.start = 1'b0;
    step();   expect_st("nom.idle", 0, F_IDLE);

    // Door handling
    bus.start = 1'b1; bus.door_Closed = 1'b0;
    step(); expect_st("door.open_idle", 0, F_IDLE);
    bus.door_Closed = 1'b1;
    step(); expect_st("door.lock", 1, F_LOCK);
    bus.door_Closed = 1'b0;
    step(); expect_st("door.open_lock", 0, F_IDLE);
    bus.start = 1'b0;

    // Cancel in LOCK returns to IDLE; cancel in IDLE is ignored
    bus.start = 1'b1; bus.door_Closed = 1'b1;
    step(); expect_st("cl.lock", 1, F_LOCK);
    bus.start = 1'b0; bus.cancel = 1'b1;
    step(); expect_st("cl.idle", 0, F_IDLE);
    step(); expect_st("cl.idle_hold", 0, F_IDLE);
    bus.cancel = 1'b0;

    // Cancel beats simultaneous sig_Completed in WASH; ignored in SPIN
    run_to_wash("cw");
    bus.cancel = 1'b1;
    pulse(3); expect_st("cw.spin", 6, F_SPIN);
    step();   expect_st("cw.spin_hold", 6, F_SPIN);
    bus.cancel = 1'b0;
    pulse(3); expect_st("cw.done", 7, F_DONE);
    bus.start = 1'b0;
    step();   expect_st("cw.idle", 0, F_IDLE);

    // Watchdog: 8 cycles in HEAT_WATER -> SPIN with fault, then SPIN timeout -> IDLE
    bus.start = 1'b1; bus.door_Closed = 1'b1;
    step(); step(); pulse(1); expect_st("wd.heat", 3, F_HEAT);
    for (int i = 1; i < 8; i++) begin
      step(); check($sformatf("wd.heat_dwell%0d", i), 32'(bus.state), 32'd3);
    end
    step(); expect_st("wd.spin", 6, F_SPIN | F_FLT);
    for (int i = 1; i < 8; i++) begin
      step(); check($sformatf("wd.spin_dwell%0d", i), 32'(bus.state), 32'd6);
    end
    step(); expect_st("wd.idle", 0, F_IDLE | F_FLT);
    step(); expect_st("wd.fault_clear", 1, F_LOCK);
    bus.start = 1'b0; bus.cancel = 1'b1;
    step(); expect_st("wd.back_idle", 0, F_IDLE);
    bus.cancel = 1'b0;

    // Asynchronous reset during RINSE
    run_to_wash("rst");
    pulse(3); expect_st("rst.rinse", 5, F_WASH);
    #3 reset = 1'b1;
    #1 expect_st("rst.async", 0, F_IDLE);
    bus.start = 1'b0;
    step(); reset = 1'b0;
    step(); expect_st("rst.resume", 0, F_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
